// File: rtl/reg_estagio_skid.sv
// rtl/reg_estagio_skid.sv - pipeline stage register with valid/ready handshake and one-entry skid buffer
module reg_estagio_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             accept;
  logic             xfer;

  // in_ready depends only on registered state, so back-pressure never forms a combinational path
  assign in_ready  = ~skid_valid_q;
  assign out_data  = main_q;
  assign out_valid = main_valid_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  assign accept = in_valid & ~skid_valid_q;
  assign xfer   = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end
    end else if (!skid_valid_q) begin
      case ({xfer, accept})
        2'b11: main_d = in_data;
        2'b10: main_valid_d = 1'b0;
        2'b01: begin
          skid_d       = in_data;
          skid_valid_d = 1'b1;
        end
        default: ;
      endcase
    end else if (xfer) begin
      // skid is refilled only behind a full main, so draining it keeps main full
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: tb/tb_reg_estagio_skid.sv
// tb/tb_reg_estagio_skid.sv - scoreboard bench for reg_estagio_skid
module tb_reg_estagio_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mq[$];
  bit          last_acc;
  bit          seq_mode = 0;
  int          n_out = 0;

  reg_estagio_skid #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks outputs against the queue model, then advances one clock and updates the model.
  task automatic tick();
    bit          m_in_ready;
    bit          m_out_valid;
    bit          acc;
    bit          xfr;
    logic [31:0] d;
    logic [31:0] popped;
    m_in_ready  = mq.size() < 2;
    m_out_valid = mq.size() > 0;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_out_valid});
    chk("occupancy", {30'd0, occupancy}, mq.size());
    if (m_out_valid) chk("out_data", out_data, mq[0]);
    acc = in_valid && m_in_ready;
    xfr = m_out_valid && out_ready;
    d   = in_data;
    @(posedge clk);
    #1;
    last_acc = acc && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      if (xfr) begin
        popped = mq.pop_front();
        if (seq_mode) chk("seq_order", popped, n_out);
        n_out++;
      end
      if (acc) mq.push_back(d);
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] next_in;

    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // pass-through
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data = 32'h11111111; tick();
    in_data = 32'h22222222; tick();
    chk("pt_occ", {30'd0, occupancy}, 32'd1);
    chk("pt_data1", out_data, 32'h22222222);
    in_data = 32'h33333333; tick();
    in_valid = 1'b0;
    chk("pt_data2", out_data, 32'h33333333);
    tick();
    tick();

    // stall into skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hAAAAAAAA; tick();
    in_data = 32'hBBBBBBBB; tick();
    chk("stall_occ", {30'd0, occupancy}, 32'd2);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_data", out_data, 32'hAAAAAAAA);
    in_data = 32'hCCCCCCCC; tick();
    tick();

    // drain skid
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("drain_data", out_data, 32'hBBBBBBBB);
    chk("drain_occ", {30'd0, occupancy}, 32'd1);
    tick();
    chk("drain_empty", {30'd0, occupancy}, 32'd0);
    tick();

    // flush with occupancy 2 and traffic on both sides
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h0000D001; tick();
    in_data = 32'h0000D002; tick();
    out_ready = 1'b1; in_data = 32'h0000D003; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick(); tick();

    // async reset between edges while stalled
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h0000E001; tick();
    in_data = 32'h0000E002; tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_occ", {30'd0, occupancy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_data", out_data, 32'd0);
    mq.delete();
    #3 rst_n = 1'b1;
    tick();

    // random back-pressure, counting pattern
    seq_mode = 1;
    n_out    = 0;
    next_in  = 0;
    cyc      = 0;
    while (n_out < 200 && cyc < 5000) begin
      in_valid  = (next_in < 200) && ($urandom_range(0, 2) != 0);
      in_data   = next_in;
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      if (last_acc) next_in++;
      cyc++;
    end
    chk("rand_count", n_out, 32'd200);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
